// File: rtl/nes_cpu_pkg.sv
// Shared 6502 timing definitions: opcode classes, access kinds, vector codes,
// sequencer states and the base last-cycle table.
package nes_cpu_pkg;

  localparam int RESET_SEQ_LEN = 7;
  localparam int CYC_W         = 3;
  // Longest legal instruction ends at cycle index 6; anything beyond is a decode error.
  localparam int MAX_LAST      = 6;

  localparam logic [1:0] VEC_NONE  = 2'b00;
  localparam logic [1:0] VEC_RESET = 2'b01;  // $FFFC
  localparam logic [1:0] VEC_IRQ   = 2'b10;  // $FFFE (IRQ/BRK)

  typedef enum logic [4:0] {
    IMP, IMM, ZP, ZPX, ABS, ABSX, INDX, INDY, BRA,
    JMPA, JMPI, JSR, RTS, RTI, BRK, PUSH, PULL, KIL
  } op_class_e;

  typedef enum logic [1:0] {RD, WR, RMW} access_e;

  typedef enum logic [1:0] {S_RST, S_VEC, S_RUN, S_JAM} seq_state_e;

  // KIL opcodes: low nibble 2 with high nibble 0-7 or odd 9/B/D/F.
  function automatic logic is_kil(input logic [7:0] ir);
    return (ir[3:0] == 4'h2) && (!ir[7] || ir[4]);
  endfunction

  // Base last-cycle index of an instruction, before page-cross/branch extensions.
  function automatic logic [2:0] last_for(input op_class_e cls, input access_e acc);
    logic [2:0] l;
    case (cls)
      ZP:            l = (acc == RMW) ? 3'd4 : 3'd2;
      ZPX, ABS:      l = (acc == RMW) ? 3'd5 : 3'd3;
      ABSX:          l = (acc == RMW) ? 3'd6 : ((acc == WR) ? 3'd4 : 3'd3);
      INDX:          l = 3'd5;
      INDY:          l = (acc == WR) ? 3'd5 : 3'd4;
      JMPA:          l = 3'd2;
      JMPI:          l = 3'd4;
      JSR, RTS, RTI: l = 3'd5;
      BRK:           l = 3'd6;
      PUSH:          l = 3'd2;
      PULL:          l = 3'd3;
      default:       l = 3'd1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: IR -> addressing class, access kind and
// base last-cycle index. Undocumented opcodes (except KIL) time as implied.
module opcode_class_decode
  import nes_cpu_pkg::*;
(
  input  logic [7:0] i_ir,
  output op_class_e  o_cls,
  output access_e    o_acc,
  output logic [2:0] o_last
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;
  logic       w_undef;
  op_class_e  w_cls;
  access_e    w_acc;

  assign w_aaa = i_ir[7:5];
  assign w_bbb = i_ir[4:2];
  assign w_cc  = i_ir[1:0];

  // Flag undocumented opcodes whose generic decode would give them a memory-mode length
  always_comb begin
    w_undef = 1'b0;
    if (w_cc == 2'b11) begin
      w_undef = 1'b1;
    end else if (w_cc == 2'b00) begin
      case (w_bbb)
        3'b001:  w_undef = (w_aaa == 3'd0) || (w_aaa == 3'd2) || (w_aaa == 3'd3);
        3'b011:  w_undef = (w_aaa == 3'd0);
        3'b101:  w_undef = (w_aaa != 3'd4) && (w_aaa != 3'd5);
        3'b111:  w_undef = (w_aaa != 3'd5);
        default: w_undef = 1'b0;
      endcase
    end else if (w_cc == 2'b10) begin
      w_undef = (w_bbb == 3'b111) && (w_aaa == 3'b100);
    end
  end

  // Specific opcodes first, then the regular aaa/bbb/cc addressing-mode grid
  always_comb begin
    w_cls = IMP;
    w_acc = RD;
    if (is_kil(i_ir)) begin
      w_cls = KIL;
    end else if (w_undef) begin
      w_cls = IMP;
    end else if (i_ir == 8'h00) begin
      w_cls = BRK;
    end else if (i_ir == 8'h20) begin
      w_cls = JSR;
    end else if (i_ir == 8'h40) begin
      w_cls = RTI;
    end else if (i_ir == 8'h60) begin
      w_cls = RTS;
    end else if (i_ir == 8'h4C) begin
      w_cls = JMPA;
    end else if (i_ir == 8'h6C) begin
      w_cls = JMPI;
    end else if (i_ir == 8'h08 || i_ir == 8'h48) begin
      w_cls = PUSH;
      w_acc = WR;
    end else if (i_ir == 8'h28 || i_ir == 8'h68) begin
      w_cls = PULL;
    end else if (i_ir[4:0] == 5'b10000) begin
      w_cls = BRA;
    end else begin
      case (w_bbb)
        3'b000:  w_cls = (w_cc == 2'b01) ? INDX : IMM;
        3'b001:  w_cls = ZP;
        3'b010:  w_cls = (w_cc == 2'b01) ? IMM : IMP;
        3'b011:  w_cls = ABS;
        3'b100:  w_cls = (w_cc == 2'b01) ? INDY : IMP;
        3'b101:  w_cls = ZPX;
        3'b110:  w_cls = (w_cc == 2'b01) ? ABSX : IMP;
        default: w_cls = ABSX;
      endcase
      if (w_cls != IMP && w_cls != IMM) begin
        if (w_aaa == 3'b100) begin
          w_acc = WR;
        end else if (w_cc == 2'b10 && w_aaa != 3'b101) begin
          w_acc = RMW;
        end
      end
    end
  end

  assign o_cls  = w_cls;
  assign o_acc  = w_acc;
  assign o_last = last_for(w_cls, w_acc);

endmodule

// File: rtl/cycle_sequencer.sv
// Per-instruction timing sequencer: turns IR/cycle into inc/res strobes,
// runs the post-reset vector sequence and halts on KIL.
module cycle_sequencer
  import nes_cpu_pkg::*;
#(
  parameter int RESET_SEQ_LEN = nes_cpu_pkg::RESET_SEQ_LEN,
  parameter int CYC_W         = nes_cpu_pkg::CYC_W
) (
  input  logic             clk_ph1,
  input  logic             rst,
  input  logic [7:0]       IR,
  input  logic [CYC_W-1:0] cycle,
  input  logic             rdy,
  input  logic             page_cross,
  input  logic             branch_taken,
  output logic             inc_cycle,
  output logic             res_cycle,
  output logic             sync,
  output logic [1:0]       vec_sel,
  output logic             wr_inhibit,
  output logic             jam
);

  localparam int               EW        = CYC_W + 1;
  localparam logic [CYC_W-1:0] VEC_LAST  = CYC_W'(RESET_SEQ_LEN - 1);
  localparam logic [CYC_W-1:0] BRK_VEC_C = CYC_W'(5);

  seq_state_e r_state;
  logic       r_ext_a;
  logic       r_ext_b;

  op_class_e        w_cls;
  access_e          w_acc;
  logic [2:0]       w_last;
  logic [CYC_W-1:0] w_last_c;
  logic [CYC_W-1:0] w_last_m1;
  logic [EW-1:0]    w_eff;
  logic             w_at_end;
  logic             w_write_cycle;
  logic             w_go;
  logic             w_kil_stop;

  opcode_class_decode u_decode (
    .i_ir   (IR),
    .o_cls  (w_cls),
    .o_acc  (w_acc),
    .o_last (w_last)
  );

  assign w_last_c  = CYC_W'(w_last);
  assign w_last_m1 = w_last_c - CYC_W'(1);
  assign w_eff     = EW'(w_last) + EW'(r_ext_a) + EW'(r_ext_b);
  // An extended length past the longest legal instruction is a decode error: end it now.
  assign w_at_end  = ({1'b0, cycle} >= w_eff) || (w_eff > EW'(MAX_LAST));
  // KIL is fetched normally at cycle 0 and freezes the core from cycle 1.
  assign w_kil_stop = (w_cls == KIL) && (cycle != '0);
  // Bus writes cannot be stretched by rdy, so write cycles always complete.
  assign w_go = rdy || w_write_cycle;

  // Identify cycles that drive a bus write for the current opcode
  always_comb begin
    w_write_cycle = 1'b0;
    case (w_cls)
      JSR: w_write_cycle = (cycle == CYC_W'(3)) || (cycle == CYC_W'(4));
      BRK: w_write_cycle = (cycle >= CYC_W'(2)) && (cycle <= CYC_W'(4));
      default: begin
        if (w_acc == WR) begin
          w_write_cycle = (cycle == w_last_c);
        end else if (w_acc == RMW) begin
          w_write_cycle = (cycle >= w_last_m1);
        end
      end
    endcase
  end

  // Strobes and status outputs from state, opcode, cycle and extension flags
  always_comb begin
    inc_cycle  = 1'b0;
    res_cycle  = 1'b0;
    sync       = 1'b0;
    vec_sel    = VEC_NONE;
    wr_inhibit = 1'b0;
    jam        = 1'b0;
    if (rst) begin
      res_cycle  = 1'b1;
      wr_inhibit = 1'b1;
    end else begin
      case (r_state)
        S_RST: begin
          res_cycle  = 1'b1;
          wr_inhibit = 1'b1;
        end
        S_VEC: begin
          vec_sel    = VEC_RESET;
          wr_inhibit = 1'b1;
          if (rdy) begin
            if (cycle >= VEC_LAST) res_cycle = 1'b1;
            else                   inc_cycle = 1'b1;
          end
        end
        S_RUN: begin
          sync = (cycle == '0);
          if (w_cls == BRK && cycle >= BRK_VEC_C) vec_sel = VEC_IRQ;
          if (w_go && !w_kil_stop) begin
            if (w_at_end) res_cycle = 1'b1;
            else          inc_cycle = 1'b1;
          end
        end
        default: begin
          jam = 1'b1;
        end
      endcase
    end
  end

  // State machine and page-cross / branch extension flags
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      r_state <= S_RST;
      r_ext_a <= 1'b0;
      r_ext_b <= 1'b0;
    end else begin
      if (res_cycle) begin
        r_ext_a <= 1'b0;
        r_ext_b <= 1'b0;
      end
      case (r_state)
        S_RST: r_state <= S_VEC;
        S_VEC: begin
          if (res_cycle) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_go) begin
            if (w_kil_stop) begin
              r_state <= S_JAM;
            end else if (!res_cycle) begin
              if (w_acc == RD && (w_cls == ABSX || w_cls == INDY) && cycle == w_last_m1) begin
                r_ext_a <= page_cross;
              end
              if (w_cls == BRA && cycle == CYC_W'(0)) begin
                r_ext_a <= branch_taken;
              end
              if (w_cls == BRA && cycle == CYC_W'(1) && r_ext_a) begin
                r_ext_b <= page_cross;
              end
            end
          end
        end
        S_JAM:   r_state <= S_JAM;
        default: r_state <= S_RST;
      endcase
    end
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Per-instruction timing sequencer for the 6502 core.
- Sits directly downstream of the instruction controller: consumes its IR and cycle outputs and produces the inc_cycle/res_cycle strobes that drive it.
- Decides each opcode's length from its addressing class, including page-cross and branch extensions.
- Also runs the post-reset 7-cycle vector sequence and the JAM halt state.

Parameters:
- RESET_SEQ_LEN, 7, number of cycles in the post-reset vector sequence (cycle indices 0..6).
- CYC_W, 3, width of the cycle index; must match the instruction controller.

Ports:
- clk_ph1 in 1: single system clock; all state updates on its rising edge.
- rst in 1: synchronous, active-high reset.
- IR in 8: current opcode from the instruction controller.
- cycle in CYC_W: current cycle index from the instruction controller.
- rdy in 1: bus ready; low stalls the sequencer.
- page_cross in 1: effective-address carry out of the low byte, from the ALU.
- branch_taken in 1: branch condition, true when the branch is taken.
- inc_cycle out 1: advance the cycle index.
- res_cycle out 1: final cycle; the controller loads IR and cycle returns to 0.
- sync out 1: opcode-fetch indicator; high when cycle==0 in S_RUN.
- vec_sel out 2: vector select; 00 none, 01 RESET ($FFFC), 10 IRQ/BRK ($FFFE).
- wr_inhibit out 1: blocks bus writes (held high during the reset sequence).
- jam out 1: high while halted on a KIL opcode.

Behaviour:
- Clock and reset: one clock (clk_ph1); rst is synchronous and active-high.
- State is registered; outputs are combinational from state, IR, cycle and the ext flags.
- Reset values: state=S_RST, ext_a=ext_b=0. Outputs while rst is high: inc_cycle=0, res_cycle=1, sync=0, vec_sel=00, wr_inhibit=1, jam=0.
- States:
  - S_RST: one cycle. res_cycle=1 forces cycle to 0. Go to S_VEC.
  - S_VEC: vec_sel=01, wr_inhibit=1, inc_cycle=1 while cycle<RESET_SEQ_LEN-1. At cycle==RESET_SEQ_LEN-1: res_cycle=1, go to S_RUN.
  - S_RUN: normal sequencing (below).
  - S_JAM: entered when IR is a KIL opcode (low nibble 2, high nibble in {0..7,9,B,D,F}) at cycle==1. jam=1, inc=res=0. Exited only by rst.
- Base last-cycle index L, from the opcode class:
  - Implied/accumulator/immediate: 1.
  - Zero page: read/write 2, RMW 4.
  - Zero page indexed: read/write 3, RMW 5.
  - Absolute: read/write 3, RMW 5.
  - Absolute indexed: read 3, write 4, RMW 6.
  - (ind,X): 5.
  - (ind),Y: read 4, write 5.
  - Branch: 1.
  - JMP abs 2; JMP ind 4.
  - JSR, RTS, RTI: 5. BRK: 6 (vec_sel=10 at cycles 5-6).
  - PHA/PHP 2; PLA/PLP 3.
- Extensions:
  - Indexed reads (abs,X / abs,Y / (ind),Y): page_cross is sampled into ext_a at cycle==L-1.
  - Branches: branch_taken is sampled into ext_a at cycle==0; page_cross is sampled into ext_b at cycle==1 only if ext_a=1.
  - Write and RMW forms ignore page_cross; the fixed extra cycle is already in L.
- Effective last index E = L + ext_a + ext_b. E<=6 by construction; a computed E>6 is a decode error: treat as res_cycle.
- In S_RUN, when rdy=1: res_cycle=1 if cycle>=E, otherwise inc_cycle=1. Never both asserted in the same cycle.
- ext_a and ext_b clear on the cycle res_cycle is asserted.
- rdy=0: inc=res=0, flags are not sampled, state holds. A write cycle ignores rdy, matching 6502 behaviour: the cycle completes.
- rst mid-instruction: aborts on the next edge into S_RST. The flags clear and any partial instruction is discarded.
- Undefined opcodes other than KIL: timed as implied (L=1).

Decomposition:
- Shared package (nes_cpu_pkg): opcode class enum (IMP, IMM, ZP, ZPX, ABS, ABSX, INDX, INDY, BRA, JMPA, JMPI, JSR, RTS, RTI, BRK, PUSH, PULL, KIL), access kind (RD/WR/RMW), vector codes, RESET_SEQ_LEN.
- Sub-module opcode_class_decode: purely combinational; IR -> {class, access kind, L}. The sequencer holds the FSM and ext flags.

Test Plan:
- Reset: hold rst high 3 cycles, release, then data=$EA (NOP). Expect res_cycle one cycle, vec_sel=01 with wr_inhibit=1 for 7 cycles, then a NOP that takes 2 cycles (res at cycle 1) with sync=1 at cycle 0.
- LDA abs,X ($BD): page_cross=0 -> res at cycle 3. page_cross=1 at cycle 2 -> res at cycle 4. STA abs,X ($9D) with page_cross=1 -> res at cycle 4 always.
- Branch BNE ($D0):
  - Not taken -> res at cycle 1.
  - Taken, no cross -> res at cycle 2.
  - Taken with page_cross=1 at cycle 1 -> res at cycle 3.
- rdy=0 for 3 cycles during LDA zp ($A5) at cycle 1 -> inc=res=0 throughout, cycle holds; after release, res at cycle 2.
- BRK ($00): vec_sel=10 at cycles 5-6, res at cycle 6. KIL ($02): jam=1 from cycle 2 onward, no strobes, cleared only by rst.
- rst asserted at cycle 3 of INC abs ($EE): next cycle is S_RST with flags 0, then a full 7-cycle reset sequence.
